// File: rtl/serial_subtractor_n_bit.sv
// Bit-serial subtractor: Z = X - Y - B_in, one bit per clock, LSB first, start/done handshake.
// Optional signed-overflow output V is enabled by defining SUB_OVERFLOW_FLAG_EN.
module serial_subtractor_n_bit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             B_in,
  output logic [WIDTH-1:0] Z,
  output logic             B_out,
  output logic             busy,
`ifdef SUB_OVERFLOW_FLAG_EN
  output logic             done,
  output logic             V
`else
  output logic             done
`endif
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] xs_q;
  logic [WIDTH-1:0] ys_q;
  logic [WIDTH-2:0] rs_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] z_q;
  logic             bo_q;
  logic             busy_q;
  logic             done_q;
`ifdef SUB_OVERFLOW_FLAG_EN
  logic             xm_q;
  logic             ym_q;
  logic             v_q;
`endif

  logic             diff_c;
  logic             br_d;
  logic [WIDTH-1:0] res_c;

  // Full-subtractor cell; res_c is the result register with the new bit entering at the MSB.
  always_comb begin
    diff_c = xs_q[0] ^ ys_q[0] ^ br_q;
    br_d   = (~xs_q[0] & ys_q[0]) | (~(xs_q[0] ^ ys_q[0]) & br_q);
    res_c  = {diff_c, rs_q};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      rs_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      z_q     <= '0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
      xm_q    <= 1'b0;
      ym_q    <= 1'b0;
      v_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            xs_q    <= X;
            ys_q    <= Y;
            br_q    <= B_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
`ifdef SUB_OVERFLOW_FLAG_EN
            xm_q    <= X[WIDTH-1];
            ym_q    <= Y[WIDTH-1];
`endif
          end
        end
        S_SHIFT: begin
          xs_q  <= xs_q >> 1;
          ys_q  <= ys_q >> 1;
          br_q  <= br_d;
          rs_q  <= res_c[WIDTH-1:1];
          cnt_q <= cnt_q + CW'(1);
          // Last bit: publish the full result together with done.
          if (cnt_q == CW'(WIDTH - 1)) begin
            z_q     <= res_c;
            bo_q    <= br_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
`ifdef SUB_OVERFLOW_FLAG_EN
            v_q     <= (xm_q ^ ym_q) & (diff_c ^ xm_q);
`endif
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Z     = z_q;
  assign B_out = bo_q;
  assign busy  = busy_q;
  assign done  = done_q;
`ifdef SUB_OVERFLOW_FLAG_EN
  assign V     = v_q;
`endif

endmodule
